// File: rtl/joy_db9_pkg.sv
// Shared types and constants for the DB9/JAMMA joystick chain scanner.
// Holds the FSM states, default timing constants and the button bit positions in JOY_STATE.
package joy_db9_pkg;

  typedef enum logic [2:0] {
    StGap, StLoad, StSettle, StSlo, StShi, StDone, StExt
  } state_e;

  localparam int unsigned DefClkDiv   = 32;
  localparam int unsigned DefNbits    = 16;
  localparam int unsigned DefScanGap  = 64;
  localparam int unsigned DefDebounce = 2;
  localparam int unsigned DefExtIdle  = 256;

  // Bit positions in JOY_STATE; player 2 occupies the upper byte.
  localparam int unsigned P1Up    = 0;
  localparam int unsigned P1Down  = 1;
  localparam int unsigned P1Left  = 2;
  localparam int unsigned P1Right = 3;
  localparam int unsigned P1Fire1 = 4;
  localparam int unsigned P1Fire2 = 5;
  localparam int unsigned P2Up    = 8;
  localparam int unsigned P2Down  = 9;
  localparam int unsigned P2Left  = 10;
  localparam int unsigned P2Right = 11;
  localparam int unsigned P2Fire1 = 12;
  localparam int unsigned P2Fire2 = 13;

endpackage

// File: rtl/joy_db9_scan_arbiter_if.sv
// Pin-side and core-side signals of the joystick chain scanner.
// master is the scanner itself; slave is the board/core side.
interface joy_db9_scan_arbiter_if #(
  parameter int unsigned NBITS = 16
);
  logic             ENABLE;
  logic             JOY_DATA;
  logic             JOY_CLK;
  logic             JOY_LOAD_N;
  logic             XJOY_CLK;
  logic             XJOY_LOAD_N;
  logic             XJOY_DATA;
  logic [NBITS-1:0] JOY_STATE;
  logic             FRAME_DONE;
  logic             CHANGED;
  logic             EXT_GRANT;

  modport master (
    input  ENABLE, JOY_DATA, XJOY_CLK, XJOY_LOAD_N,
    output JOY_CLK, JOY_LOAD_N, XJOY_DATA, JOY_STATE, FRAME_DONE, CHANGED, EXT_GRANT
  );

  modport slave (
    output ENABLE, JOY_DATA, XJOY_CLK, XJOY_LOAD_N,
    input  JOY_CLK, JOY_LOAD_N, XJOY_DATA, JOY_STATE, FRAME_DONE, CHANGED, EXT_GRANT
  );
endinterface

// File: rtl/joy_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks, on count CLK_DIV-1.
module joy_tick_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/joy_db9_scan_arbiter.sv
// Scans the 74HC165 joystick chain, debounces it into JOY_STATE and hands the chain
// pins to an external scanner between frames when it asks for them.
module joy_db9_scan_arbiter
  import joy_db9_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned NBITS    = DefNbits,
  parameter int unsigned SCAN_GAP = DefScanGap,
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned EXT_IDLE = DefExtIdle
) (
  input logic                    CLOCK_50,
  input logic                    RESET_N,
  joy_db9_scan_arbiter_if.master bus
);
  localparam int unsigned GapW  = $clog2(SCAN_GAP + 1);
  localparam int unsigned BitW  = $clog2(NBITS + 1);
  localparam int unsigned IdleW = $clog2(EXT_IDLE + 1);

  logic tick;

  joy_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .tick (tick)
  );

  state_e            fsm_q;
  logic [GapW-1:0]   gap_q;
  logic [BitW-1:0]   bit_q;
  logic [IdleW-1:0]  idle_q;
  logic [NBITS-1:0]  shreg_q, shadow_q, joy_state_q;
  logic [3:0]        dcnt_q;
  logic              clk_q, load_n_q, grant_q, req_q, frame_done_q, changed_q;
  logic [2:0]        xclk_q, xload_q;

  // Synchronisers feed edge detection only; the pin mux below uses the raw inputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      xclk_q  <= '0;
      xload_q <= '1;
    end else begin
      xclk_q  <= {xclk_q[1:0], bus.XJOY_CLK};
      xload_q <= {xload_q[1:0], bus.XJOY_LOAD_N};
    end
  end

  logic x_edge, x_req;
  assign x_edge = (xclk_q[2] ^ xclk_q[1]) | (xload_q[2] ^ xload_q[1]);
  assign x_req  = xload_q[2] & ~xload_q[1];

  logic [NBITS-1:0] frame_val, shadow_nxt;
  logic [3:0]       dcnt_nxt;
  logic             same, do_update;

  always_comb begin
    frame_val  = ~shreg_q;
    same       = (frame_val == shadow_q);
    shadow_nxt = same ? shadow_q : frame_val;
    if (!same) begin
      dcnt_nxt = 4'd1;
    end else if (dcnt_q == 4'hF) begin
      dcnt_nxt = dcnt_q;
    end else begin
      dcnt_nxt = dcnt_q + 4'd1;
    end
    do_update = (dcnt_nxt >= 4'(DEBOUNCE)) && (shadow_nxt != joy_state_q);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q        <= StGap;
      gap_q        <= '0;
      bit_q        <= '0;
      idle_q       <= '0;
      shreg_q      <= '0;
      shadow_q     <= '0;
      joy_state_q  <= '0;
      dcnt_q       <= '0;
      clk_q        <= 1'b0;
      load_n_q     <= 1'b1;
      grant_q      <= 1'b0;
      req_q        <= 1'b0;
      frame_done_q <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      changed_q    <= 1'b0;
      if (x_req && fsm_q != StExt) req_q <= 1'b1;
      unique case (fsm_q)
        StGap: begin
          if (req_q) begin
            fsm_q   <= StExt;
            grant_q <= 1'b1;
            req_q   <= 1'b0;
            idle_q  <= '0;
          end else if (tick) begin
            if (gap_q == GapW'(SCAN_GAP - 1)) begin
              if (bus.ENABLE) begin
                fsm_q    <= StLoad;
                load_n_q <= 1'b0;
                bit_q    <= '0;
              end
            end else begin
              gap_q <= gap_q + GapW'(1);
            end
          end
        end
        StLoad: if (tick) begin
          fsm_q    <= StSettle;
          load_n_q <= 1'b1;
        end
        StSettle: if (tick) fsm_q <= StSlo;
        StSlo: if (tick) begin
          shreg_q <= {shreg_q[NBITS-2:0], bus.JOY_DATA};
          bit_q   <= bit_q + BitW'(1);
          clk_q   <= 1'b1;
          fsm_q   <= StShi;
        end
        StShi: if (tick) begin
          clk_q <= 1'b0;
          fsm_q <= (bit_q == BitW'(NBITS)) ? StDone : StSlo;
        end
        StDone: begin
          frame_done_q <= 1'b1;
          shadow_q     <= shadow_nxt;
          dcnt_q       <= dcnt_nxt;
          if (do_update) begin
            joy_state_q <= shadow_nxt;
            changed_q   <= 1'b1;
          end
          if (req_q) begin
            fsm_q   <= StExt;
            grant_q <= 1'b1;
            req_q   <= 1'b0;
            idle_q  <= '0;
          end else begin
            fsm_q <= StGap;
            gap_q <= '0;
          end
        end
        StExt: begin
          if (x_edge) begin
            idle_q <= '0;
          end else if (tick) begin
            if (idle_q == IdleW'(EXT_IDLE - 1)) begin
              fsm_q   <= StGap;
              grant_q <= 1'b0;
              gap_q   <= '0;
            end else begin
              idle_q <= idle_q + IdleW'(1);
            end
          end
        end
        default: fsm_q <= StGap;
      endcase
    end
  end

  assign bus.JOY_CLK    = grant_q ? bus.XJOY_CLK : clk_q;
  assign bus.JOY_LOAD_N = grant_q ? bus.XJOY_LOAD_N : load_n_q;
  assign bus.XJOY_DATA  = bus.JOY_DATA;
  assign bus.JOY_STATE  = joy_state_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.CHANGED    = changed_q;
  assign bus.EXT_GRANT  = grant_q;
endmodule

// File: tb/tb_joy_db9_scan_arbiter.sv
// Bench for joy_db9_scan_arbiter: 74HC165 chain model, frame-level debounce model
// checked every cycle, and directed timing/arbitration/reset scenarios.
module tb_joy_db9_scan_arbiter;
  localparam int unsigned NB = 16;
  localparam int unsigned DB = 2;

  logic CLOCK_50, RESET_N;
  joy_db9_scan_arbiter_if #(.NBITS(NB)) bus ();

  joy_db9_scan_arbiter #(
    .CLK_DIV (32),
    .NBITS   (NB),
    .SCAN_GAP(64),
    .DEBOUNCE(DB),
    .EXT_IDLE(256)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for event (t=%0t)", name, $time);
  endtask

  // 74HC165 chain: parallel load while LOAD_N low, shift toward QH on CLK rise.
  logic [NB-1:0] pat, chain;
  always @(negedge bus.JOY_LOAD_N or posedge bus.JOY_CLK) begin
    if (!bus.JOY_LOAD_N) chain <= pat;
    else chain <= {chain[NB-2:0], 1'b1};
  end
  assign bus.JOY_DATA = chain[NB-1];

  // Event monitor sampled on the falling clock edge.
  int cyc = 0, load_falls = 0, last_fall = 0, prev_fall = 0, load_low_len = 0;
  int rises = 0, last_rise = 0, rise_period = 0, frame_rises = 0;
  int fd_count = 0, chg_count = 0, grant_fall = 0;
  logic [NB-1:0] cap;
  logic p_load = 1'b1, p_clk = 1'b0, p_grant = 1'b0;

  initial begin
    cap = '0;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (!bus.EXT_GRANT && !p_grant) begin
        if (p_load && !bus.JOY_LOAD_N) begin
          load_falls++;
          prev_fall = last_fall;
          last_fall = cyc;
          cap = pat;
          rises = 0;
        end
        if (!p_load && bus.JOY_LOAD_N) load_low_len = cyc - last_fall;
        if (!p_clk && bus.JOY_CLK) begin
          rises++;
          rise_period = cyc - last_rise;
          last_rise = cyc;
        end
      end
      if (bus.FRAME_DONE) begin
        fd_count++;
        frame_rises = rises;
      end
      if (bus.CHANGED) chg_count++;
      if (p_grant && !bus.EXT_GRANT) grant_fall = cyc;
      p_load = bus.JOY_LOAD_N;
      p_clk = bus.JOY_CLK;
      p_grant = bus.EXT_GRANT;
    end
  end

  // Frame-level model: state follows a value once the last DB frames all agree on it.
  logic [NB-1:0] m_state = '0;
  logic m_chg = 1'b0;
  logic [NB-1:0] hist[$];

  initial begin
    logic [NB-1:0] v, nxt;
    bit all_eq;
    forever begin
      @(negedge CLOCK_50);
      if (!RESET_N) begin
        m_state = '0;
        m_chg = 1'b0;
        hist.delete();
      end else if (bus.FRAME_DONE) begin
        v = ~cap;
        hist.push_back(v);
        nxt = m_state;
        if (hist.size() >= DB) begin
          all_eq = 1'b1;
          for (int k = 0; k < DB; k++) if (hist[hist.size() - 1 - k] != v) all_eq = 1'b0;
          if (all_eq) nxt = v;
        end
        m_chg = (nxt != m_state);
        m_state = nxt;
      end else begin
        m_chg = 1'b0;
      end
      check("joy_state", 32'(bus.JOY_STATE), 32'(m_state));
      check("changed", 32'(bus.CHANGED), 32'(m_chg));
      check("xjoy_data", 32'(bus.XJOY_DATA), 32'(bus.JOY_DATA));
      if (bus.EXT_GRANT) begin
        check("ext_clk_mux", 32'(bus.JOY_CLK), 32'(bus.XJOY_CLK));
        check("ext_load_mux", 32'(bus.JOY_LOAD_N), 32'(bus.XJOY_LOAD_N));
      end
    end
  end

  task automatic wait_fd(input int n, input int budget, input string name);
    int target = fd_count + n;
    int t = 0;
    while (fd_count < target && t < budget) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (fd_count < target) timeout(name);
  endtask

  task automatic wait_lf(input int budget, input string name);
    int target = load_falls + 1;
    int t = 0;
    while (load_falls < target && t < budget) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (load_falls < target) timeout(name);
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    int t = 0;
    while (rises < n && t < budget) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (rises < n) timeout(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_joy_clk"}, 32'(bus.JOY_CLK), 0);
    check({tag, "_joy_load_n"}, 32'(bus.JOY_LOAD_N), 1);
    check({tag, "_joy_state"}, 32'(bus.JOY_STATE), 0);
    check({tag, "_frame_done"}, 32'(bus.FRAME_DONE), 0);
    check({tag, "_changed"}, 32'(bus.CHANGED), 0);
    check({tag, "_ext_grant"}, 32'(bus.EXT_GRANT), 0);
  endtask

  initial begin
    int lf, d, chg0, t;
    RESET_N = 1'b1;
    bus.ENABLE = 1'b0;
    bus.XJOY_CLK = 1'b0;
    bus.XJOY_LOAD_N = 1'b1;
    pat = 16'hFFFE;
    #2 RESET_N = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1 check_reset_outputs("reset");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    bus.ENABLE = 1'b1;

    // Two frames of 16'hFFFE: timing and debounced update.
    wait_fd(1, 3400, "frame1");
    check("bits_per_frame", 32'(frame_rises), 16);
    check("joy_clk_period", 32'(rise_period), 64);
    check("load_low_clk", 32'(load_low_len), 32);
    check("state_after_f1", 32'(bus.JOY_STATE), 0);
    wait_fd(1, 3400, "frame2");
    repeat (2) @(negedge CLOCK_50);
    check("frame_period", 32'(last_fall - prev_fall), 1088 + 64 * 32);
    check("state_after_f2", 32'(bus.JOY_STATE), 32'h0001);
    check("frame_done_count", 32'(fd_count), 2);
    check("changed_count", 32'(chg_count), 1);

    // Release, then a one-frame glitch that must be rejected.
    pat = 16'hFFFF;
    wait_fd(2, 6600, "release");
    repeat (2) @(negedge CLOCK_50);
    check("state_released", 32'(bus.JOY_STATE), 0);
    check("changed_release", 32'(chg_count), 2);
    pat = 16'hFFFE;
    wait_fd(1, 3400, "glitch");
    pat = 16'hFFFF;
    wait_fd(2, 6600, "after_glitch");
    repeat (2) @(negedge CLOCK_50);
    check("state_glitch", 32'(bus.JOY_STATE), 0);
    check("changed_glitch", 32'(chg_count), 2);

    // External request during bit 5: granted only at DONE.
    wait_lf(3400, "ext_frame_start");
    wait_rises(5, 500, "ext_bit5");
    bus.XJOY_LOAD_N = 1'b0;
    repeat (40) @(negedge CLOCK_50);
    check("no_grant_midframe", 32'(bus.EXT_GRANT), 0);
    wait_fd(1, 1200, "ext_frame_done");
    check("ext_frame_bits", 32'(frame_rises), 16);
    check("grant_at_done", 32'(bus.EXT_GRANT), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      bus.XJOY_CLK = ~bus.XJOY_CLK;
      #1 check("joy_clk_tracks_x", 32'(bus.JOY_CLK), 32'(bus.XJOY_CLK));
      repeat (10) @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    bus.XJOY_LOAD_N = 1'b1;
    #1 check("joy_load_tracks_x", 32'(bus.JOY_LOAD_N), 1);
    lf = cyc;
    t = 0;
    while (bus.EXT_GRANT && t < 9000) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (bus.EXT_GRANT) timeout("ext_release");
    d = grant_fall - lf;
    check("ext_idle_256_ticks", 32'(d >= 8150 && d <= 8215), 1);
    check("released_joy_clk", 32'(bus.JOY_CLK), 0);
    check("released_load_n", 32'(bus.JOY_LOAD_N), 1);
    wait_lf(2200, "resume_after_ext");
    d = last_fall - grant_fall;
    check("gap_after_ext", 32'(d >= 2046 && d <= 2050), 1);

    // ENABLE dropped during bit 3: frame finishes, then scanning holds.
    wait_rises(3, 300, "en_bit3");
    bus.ENABLE = 1'b0;
    lf = load_falls;
    wait_fd(1, 1200, "en_frame_done");
    check("en_frame_bits", 32'(frame_rises), 16);
    repeat (6400) @(negedge CLOCK_50);
    check("no_loads_disabled", 32'(load_falls - lf), 0);
    bus.ENABLE = 1'b1;
    wait_lf(80, "resume_enable");
    check("loads_resumed", 32'(load_falls - lf), 1);

    // Reset asynchronously in the middle of a frame.
    pat = 16'hFFFE;
    wait_fd(1, 1200, "pre_reset_a");
    wait_fd(2, 6600, "pre_reset_b");
    repeat (2) @(negedge CLOCK_50);
    check("state_pre_reset", 32'(bus.JOY_STATE), 32'h0001);
    wait_lf(2200, "reset_frame");
    wait_rises(2, 200, "reset_shi");
    @(posedge CLOCK_50);
    #5 RESET_N = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    chg0 = chg_count;
    wait_fd(1, 3400, "post_reset_f1");
    repeat (2) @(negedge CLOCK_50);
    check("post_reset_state_f1", 32'(bus.JOY_STATE), 0);
    wait_fd(1, 3400, "post_reset_f2");
    repeat (2) @(negedge CLOCK_50);
    check("post_reset_state_f2", 32'(bus.JOY_STATE), 32'h0001);
    check("post_reset_changed", 32'(chg_count - chg0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
